// File: rtl/audio_out_serializer_mc_pkg.sv
// Shared constants and helpers for the audio output serializer.
// Holds the underflow counter width, the serial framing mode values and a saturating increment.
package audio_out_serializer_mc_pkg;

  localparam int unsigned UNDERFLOW_CNT_WIDTH = 16;

  localparam int unsigned MODE_LJ  = 0;
  localparam int unsigned MODE_I2S = 1;

  typedef logic [UNDERFLOW_CNT_WIDTH-1:0] underflow_cnt_t;

  function automatic underflow_cnt_t sat_inc(input underflow_cnt_t v);
    return (v == '1) ? v : v + underflow_cnt_t'(1);
  endfunction

endpackage

// File: rtl/audio_out_serializer_mc_fifo.sv
// Single-clock FIFO with a read port that shows the head word before it is popped.
// A write to a full FIFO is dropped. A write and a pop in the same cycle leave the count unchanged.
module audio_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 128,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [ADDR_WIDTH:0]   words_used_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam logic [ADDR_WIDTH:0]   DepthCnt = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   CntOne   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PtrOne   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  wr_accept, rd_accept;

  assign full_o       = (count_q == DepthCnt);
  assign empty_o      = (count_q == '0);
  assign words_used_o = count_q;
  assign rd_data_o    = mem_q[rd_ptr_q];

  assign wr_accept = wr_en_i && !full_o && !reset_i;
  assign rd_accept = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_accept ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = rd_accept ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d  = count_q;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; clearing the pointers and the count empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/audio_out_serializer_mc.sv
// Two-channel audio FIFO front end that feeds an MSB-first serial DAC stream.
// The LR strobes select the slot, and the bit-clock falling strobes shift the data out.
module audio_out_serializer_mc
  import audio_out_serializer_mc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned FIFO_DEPTH       = 128,
  parameter int unsigned ADDR_WIDTH       = 7,
  parameter int unsigned I2S_MODE         = 1,
  parameter int unsigned UNDERFLOW_REPEAT = 0
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           enable_i,
  input  logic                           bit_clk_rising_edge_i,
  input  logic                           bit_clk_falling_edge_i,
  input  logic                           left_right_clk_rising_edge_i,
  input  logic                           left_right_clk_falling_edge_i,
  input  logic [DATA_WIDTH-1:0]          left_channel_data_i,
  input  logic [DATA_WIDTH-1:0]          right_channel_data_i,
  input  logic                           left_channel_data_en_i,
  input  logic                           right_channel_data_en_i,
  output logic [ADDR_WIDTH:0]            left_channel_fifo_write_space_o,
  output logic [ADDR_WIDTH:0]            right_channel_fifo_write_space_o,
  output logic [UNDERFLOW_CNT_WIDTH-1:0] underflow_count_o,
  output logic                           serial_audio_out_data_o
);

  localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

  logic                  unused_bit_clk_rising;
  logic                  pop_l, pop_r;
  logic [DATA_WIDTH-1:0] l_rd_data, r_rd_data;
  logic [ADDR_WIDTH:0]   l_used, r_used;
  logic                  l_empty, r_empty;
  logic                  l_full_unused, r_full_unused;

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] last_l_q, last_l_d;
  logic [DATA_WIDTH-1:0] last_r_q, last_r_d;
  logic                  left_was_read_q, left_was_read_d;
  logic                  skip_q, skip_d;
  underflow_cnt_t        ucnt_q, ucnt_d;
  logic                  serial_q;
  logic [ADDR_WIDTH:0]   l_space_q, r_space_q;
  logic                  load, underflow;

  // Only the falling bit-clock edge matters; the DAC samples data on the rising edge.
  assign unused_bit_clk_rising = bit_clk_rising_edge_i;

  audio_sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_left_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .wr_en_i     (left_channel_data_en_i),
    .wr_data_i   (left_channel_data_i),
    .rd_en_i     (pop_l),
    .rd_data_o   (l_rd_data),
    .words_used_o(l_used),
    .empty_o     (l_empty),
    .full_o      (l_full_unused)
  );

  audio_sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_right_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .wr_en_i     (right_channel_data_en_i),
    .wr_data_i   (right_channel_data_i),
    .rd_en_i     (pop_r),
    .rd_data_o   (r_rd_data),
    .words_used_o(r_used),
    .empty_o     (r_empty),
    .full_o      (r_full_unused)
  );

  always_comb begin
    pop_l           = 1'b0;
    pop_r           = 1'b0;
    load            = 1'b0;
    underflow       = 1'b0;
    shift_d         = shift_q;
    last_l_d        = last_l_q;
    last_r_d        = last_r_q;
    left_was_read_d = left_was_read_q;
    skip_d          = skip_q;
    ucnt_d          = ucnt_q;

    if (left_right_clk_rising_edge_i) begin
      load            = 1'b1;
      left_was_read_d = 1'b0;
      // A left word is popped only when the matching right word is already queued.
      if (enable_i && !l_empty && !r_empty) begin
        pop_l           = 1'b1;
        shift_d         = l_rd_data;
        last_l_d        = l_rd_data;
        left_was_read_d = 1'b1;
      end else begin
        shift_d   = (enable_i && UNDERFLOW_REPEAT != 0) ? last_l_q : '0;
        underflow = enable_i;
      end
    end else if (left_right_clk_falling_edge_i) begin
      load            = 1'b1;
      left_was_read_d = 1'b0;
      if (enable_i && left_was_read_q && !r_empty) begin
        pop_r    = 1'b1;
        shift_d  = r_rd_data;
        last_r_d = r_rd_data;
      end else begin
        shift_d   = (enable_i && UNDERFLOW_REPEAT != 0) ? last_r_q : '0;
        underflow = enable_i;
      end
    end else if (bit_clk_falling_edge_i) begin
      if (skip_q) begin
        skip_d = 1'b0;
      end else begin
        shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
      end
    end

    if (load) begin
      skip_d = (I2S_MODE == MODE_I2S);
    end
    if (underflow) begin
      ucnt_d = sat_inc(ucnt_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shift_q         <= '0;
      last_l_q        <= '0;
      last_r_q        <= '0;
      left_was_read_q <= 1'b0;
      skip_q          <= 1'b0;
      ucnt_q          <= '0;
      serial_q        <= 1'b0;
    end else begin
      shift_q         <= shift_d;
      last_l_q        <= last_l_d;
      last_r_q        <= last_r_d;
      left_was_read_q <= left_was_read_d;
      skip_q          <= skip_d;
      ucnt_q          <= ucnt_d;
      serial_q        <= shift_q[DATA_WIDTH-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      l_space_q <= '0;
      r_space_q <= '0;
    end else begin
      l_space_q <= DepthCnt - l_used;
      r_space_q <= DepthCnt - r_used;
    end
  end

  assign left_channel_fifo_write_space_o  = l_space_q;
  assign right_channel_fifo_write_space_o = r_space_q;
  assign underflow_count_o                = ucnt_q;
  assign serial_audio_out_data_o          = serial_q;

endmodule

// File: doc/audio_out_serializer_mc.md
AUDIO_OUT_SERIALIZER_MC -- requirements
Module: audio_out_serializer_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning sample width in bits (range 8..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 128, meaning words per channel FIFO (power of 2, 4..1024).
REQ-003 SHALL have parameter ADDR_WIDTH, default 7, meaning log2(FIFO_DEPTH).
REQ-004 SHALL have parameter I2S_MODE, default 1, meaning 1 = one-bit-clock delay after LR edge, 0 = left-justified.
REQ-005 SHALL have parameter UNDERFLOW_REPEAT, default 0, meaning 1 = resend last sample on underflow, 0 = send zero.
REQ-006 clk  input  1  system clock; the only clock.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  1 = normal output; 0 = mute, no FIFO reads.
REQ-009 bit_clk_rising_edge, bit_clk_falling_edge  input  1 each  one-cycle strobes from the clock generator.
REQ-010 left_right_clk_rising_edge, left_right_clk_falling_edge  input  1 each  one-cycle strobes; rising = left slot start, falling = right slot start.
REQ-011 left_channel_data, right_channel_data  input  DATA_WIDTH each  samples to queue.
REQ-012 left_channel_data_en, right_channel_data_en  input  1 each  write strobes; ignored when the target FIFO is full.
REQ-013 left_channel_fifo_write_space, right_channel_fifo_write_space  output  ADDR_WIDTH+1 each  registered free words.
REQ-014 underflow_count  output  16  saturating count of substituted slots.
REQ-015 serial_audio_out_data  output  1  registered serial DAC data, MSB first.

Function
REQ-016 write_space SHALL equal FIFO_DEPTH minus words used, registered with one clk latency, and reach FIFO_DEPTH one cycle after reset release with FIFOs empty.
REQ-017 On left_right_clk_rising_edge with enable=1 and both FIFOs non-empty, the block SHALL pop left, load it into the shift register, and set left_was_read.
REQ-018 On left_right_clk_falling_edge with left_was_read=1, the block SHALL pop right, load it, and clear left_was_read; pops SHALL always be paired, left then right.
REQ-019 Otherwise, on either LR edge, the block SHALL load zero (UNDERFLOW_REPEAT=0) or the last sample sent on that channel (UNDERFLOW_REPEAT=1) and SHALL increment underflow_count by 1 when enable=1, saturating at 16'hFFFF.
REQ-020 With enable=0, the block SHALL load zero on every LR edge, perform no pops, and not count underflow.
REQ-021 On bit_clk_falling_edge without an LR edge, the shift register SHALL shift left one bit with zero fill.
REQ-022 In I2S_MODE=1, the first bit_clk_falling_edge after each load SHALL be skipped (one-bit delay); in I2S_MODE=0, no edge is skipped.
REQ-023 Priority SHALL be: reset > LR-edge load > bit-clock shift; an LR edge coincident with bit_clk_falling_edge loads only.
REQ-024 serial_audio_out_data SHALL equal the shift register MSB delayed one clk.
REQ-025 A write and a pop in the same cycle on one FIFO SHALL both take effect, leaving the word count unchanged.
REQ-026 A write to a full FIFO SHALL be dropped without corrupting contents.
REQ-027 A pop from an empty FIFO SHALL not occur by construction.

Reset
REQ-028 Reset SHALL clear both FIFOs, the shift register, left_was_read, the last-sample registers and underflow_count, and drive serial_audio_out_data to 0 and write_space outputs to 0.
REQ-029 Reset asserted mid-frame SHALL take effect on the next clk edge; the first frame after reset SHALL start on the next left_right_clk_rising_edge.

Structure
REQ-030 A shared package SHALL hold the underflow-counter width (16) and mode constants (MODE_I2S=1, MODE_LJ=0).
REQ-031 Each channel FIFO SHALL be one instance of sub-module audio_sync_fifo (DATA_WIDTH, FIFO_DEPTH, ADDR_WIDTH), providing words_used, empty and full.

Verification
REQ-032 DATA_WIDTH=16, I2S_MODE=1: write L=16'hA5C3 and R=16'h0F0F, then run one frame -> after the first bit-clock delay, output shows A5C3 MSB-first, then 0 fill; the right slot shows 0F0F; underflow_count=0.
REQ-033 I2S_MODE=0, same data -> bit 15 of 16'hA5C3 appears one clk after the LR rising strobe, with no skipped edge.
REQ-034 Write left only (16'h1234), run a frame -> no pop, both slots zero, underflow_count=2, left write_space=FIFO_DEPTH-1.
REQ-035 UNDERFLOW_REPEAT=1: send one pair (16'h1111/16'h2222), then starve for one frame -> second frame resends 1111/2222, and underflow_count increments by 2.
REQ-036 Fill the left FIFO with FIFO_DEPTH+3 writes -> write_space=0, and the extra 3 words are dropped; reading back yields the first FIFO_DEPTH words in order.
REQ-037 Assert reset during the 5th bit of a left slot -> output goes to 0 next clk, counters clear, write_space goes to 0 and then to FIFO_DEPTH.
